uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART TX byte stream (the TX CDC FIFO write port, system clock domain) between NUM_REQ requester channels, e.g. CPU register path, DMA engine and debug console.
- Arbitration is round-robin at packet granularity: a granted requester owns the stream until it marks a last byte or hits the MAX_BURST byte cap.
- It sits between the requesters and the TX FIFO valid/ready write port.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8)
- DATA_WIDTH, 8, byte width of each channel and of the TX port
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255)

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  synchronous abort of the current grant
- req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester byte
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_last_i  in  NUM_REQ  per-requester end-of-packet marker, qualified by valid
- req_ready_o  out  NUM_REQ  per-requester byte accepted
- tx_data_o  out  DATA_WIDTH  byte to the TX FIFO
- tx_valid_o  out  1  byte valid to the TX FIFO
- tx_ready_i  in  1  TX FIFO can accept a byte
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle
- grant_id_o  out  $clog2(NUM_REQ)  index of the current owner
- busy_o  out  1  a grant is held

Behaviour:
- Reset (arst_i=1, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - All outputs are 0: grant_o, grant_id_o, busy_o, tx_valid_o, tx_data_o, req_ready_o.
- States: IDLE, XFER.
- IDLE:
  - tx_valid_o=0 and req_ready_o=0.
  - If any req_valid_i is set, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the pick as the grant and go to XFER. Arbitration latency is 1 cycle; no byte transfers in the decision cycle.
- XFER (owner g), combinational pass-through:
  - tx_data_o=req_data_i[g], tx_valid_o=req_valid_i[g].
  - req_ready_o[g]=tx_ready_i; all other req_ready_o bits are 0.
  - A beat is the cycle where tx_valid_o & tx_ready_i; each beat increments beat_cnt.
- Release: on a beat with req_last_i[g]=1, or on the beat where beat_cnt+1==MAX_BURST.
  - Next state is IDLE, rr_ptr=(g+1) mod NUM_REQ, beat_cnt=0.
  - Exactly one idle bubble cycle follows before the next grant.
- Owner drops valid mid-packet: the grant is held indefinitely (no timeout); other requesters wait.
- Valid-drop and data-hold rules:
  - Non-owner requesters may toggle valid freely; they see no ready.
  - The owner must hold data stable while valid && !ready (AXI-stream rule). The arbiter does not check this.
- Last and MAX_BURST on the same beat: single release, same result as either condition alone.
- flush_i:
  - In XFER: return to IDLE next cycle, beat_cnt=0, rr_ptr=(g+1) mod NUM_REQ. Any beat in the flush cycle still completes.
  - In IDLE: no grant is taken that cycle.
- beat_cnt width is $clog2(MAX_BURST+1). It never wraps, because release occurs at MAX_BURST.
- grant_o, grant_id_o and busy_o are registered and change only on IDLE<->XFER transitions.
- Reset mid-packet: the byte is discarded immediately; the requester must re-send the packet after reset.

Decomposition:
- uart_arb_pkg: state enum (ARB_IDLE, ARB_XFER), a clog2 helper, and the default constants NUM_REQ_DEF and MAX_BURST_DEF.
- Sub-module uart_rr_pick (combinational): inputs valid vector and rr_ptr; outputs found, one-hot grant and grant index, via a rotated priority encoder.
- The FSM, counter and muxes stay in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready_i=1.
  - grant_o=0001 one cycle after the first valid; 3 beats appear in order; busy_o drops the cycle after the 0x43 beat.
- Round robin: req0..req3 all valid with 1-byte packets (last=1), tx_ready_i=1.
  - Grant order is 0,1,2,3,0; each grant lasts 1 beat followed by 1 idle bubble.
- Burst cap: MAX_BURST=16 and req2 streams 20 bytes without last.
  - Release after the 16th beat; if req3 is valid it is granted next; req2 resumes with its byte 17 on a later grant.
- Backpressure: req1 owns the stream and tx_ready_i toggles 1,0,0,1.
  - Exactly 2 beats; req_ready_o[1] mirrors tx_ready_i; no non-owner ever sees ready.
- Flush/reset:
  - flush_i pulses mid-packet for req0 while req1 is valid: next grant is req1.
  - arst_i asserted mid-packet: all outputs are 0 immediately; after release, the first grant goes to the lowest valid index (rr_ptr=0).

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
package uart_arb_pkg;

    // State table for uart_tx_arbiter:
    // state    | meaning
    // ARB_IDLE | no owner; arbitration decision is taken this cycle
    // ARB_XFER | one requester owns the TX stream; bytes pass straight through
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 16;

    // Ceiling log2, used for index and counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotated priority encoder: first valid requester at or after rr_ptr, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = clog2(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and keep the first hit.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found                                = 1'b1;
                grant[(int'(rr_ptr) + i) % NUM_REQ]  = 1'b1;
                grant_id                             = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the UART TX FIFO write port.
//
// state    | meaning
// ARB_IDLE | no owner; pick next requester from rr_ptr, no byte moves
// ARB_XFER | owner passes bytes straight to the TX port until last, burst cap or flush
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    localparam int ID_W      = clog2(NUM_REQ),
    localparam int CNT_W     = clog2(MAX_BURST + 1)
) (
    input  logic                               clk_i,
    input  logic                               arst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0]                 req_last_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [DATA_WIDTH-1:0]              tx_data_o,
    output logic                               tx_valid_o,
    input  logic                               tx_ready_i,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic [ID_W-1:0]                    grant_id_o,
    output logic                               busy_o
);

    arb_state_t         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_found;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_id;
    logic               beat;
    logic               last_beat;
    logic [ID_W-1:0]    next_ptr;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid    (req_valid_i),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .grant    (pick_grant),
        .grant_id (pick_id)
    );

    // Owner's byte goes straight to the TX port; nothing moves while idle.
    always_comb begin
        tx_data_o   = '0;
        tx_valid_o  = 1'b0;
        req_ready_o = '0;
        if (state == ARB_XFER) begin
            tx_data_o   = req_data_i[grant_id_q];
            tx_valid_o  = req_valid_i[grant_id_q];
            req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
        end
    end

    // A beat on last or on the cap-reaching byte ends the grant; both together is one release.
    assign beat      = tx_valid_o & tx_ready_i;
    assign last_beat = beat & (req_last_i[grant_id_q] | (beat_cnt == CNT_W'(MAX_BURST - 1)));
    assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    // Grant FSM, beat counter and round-robin pointer.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            grant_id_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found && !flush_i) begin
                        state      <= ARB_XFER;
                        grant_q    <= pick_grant;
                        grant_id_q <= pick_id;
                        busy_q     <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                ARB_XFER: begin
                    if (flush_i || last_beat) begin
                        state      <= ARB_IDLE;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        busy_q     <= 1'b0;
                        beat_cnt   <= '0;
                        rr_ptr     <= next_ptr;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte queues, a packet-level
// arbitration model producing the expected TX byte stream, and a monitor.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    typedef struct packed {
        logic       rel;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   arst_i;
    logic                   flush_i;
    logic [NR-1:0][DW-1:0]  req_data_i;
    logic [NR-1:0]          req_valid_i;
    logic [NR-1:0]          req_last_i;
    logic [NR-1:0]          req_ready_o;
    logic [DW-1:0]          tx_data_o;
    logic                   tx_valid_o;
    logic                   tx_ready_i;
    logic [NR-1:0]          grant_o;
    logic [1:0]             grant_id_o;
    logic                   busy_o;

    int   checks = 0;
    int   errors = 0;
    logic [8:0] src_mem [NR][64];
    int   src_len [NR];
    int   src_pos [NR];
    int   model_ptr;
    exp_t exp_q [$];
    bit   drv_en;
    bit   gaps;
    int   ready_mode;
    int   cyc;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .flush_i     (flush_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void clear_src();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endfunction

    function automatic void add_byte(input int r, input logic [7:0] d, input bit last);
        src_mem[r][src_len[r]] = {last, d};
        src_len[r]++;
    endfunction

    // Packet-level model: each grant goes to the first requester with bytes left,
    // scanning from the pointer; it takes bytes until last, MB bytes, or the forced cut.
    function automatic void model_run(input int first_cut);
        int pos [NR];
        int g;
        int n;
        int cut;
        int idx;
        bit found;
        bit rel;
        exp_t e;
        cut = first_cut;
        for (int i = 0; i < NR; i++) pos[i] = src_pos[i];
        for (int guard = 0; guard < 1000; guard++) begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NR; k++) begin
                idx = (model_ptr + k) % NR;
                if (!found && pos[idx] < src_len[idx]) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            if (!found) break;
            n = 0;
            rel = 1'b0;
            while (!rel && pos[g] < src_len[g]) begin
                n++;
                rel    = src_mem[g][pos[g]][8] || (n == MB) || (cut > 0 && n == cut);
                e.rel  = rel;
                e.id   = 2'(g);
                e.data = src_mem[g][pos[g]][7:0];
                exp_q.push_back(e);
                pos[g]++;
            end
            model_ptr = (g + 1) % NR;
            cut = 0;
        end
    endfunction

    // Requester sources and TX FIFO ready: inputs change 1 time unit after the edge.
    initial begin
        logic [NR-1:0] acc;
        bit has;
        forever begin
            @(negedge clk_i);
            acc = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) src_pos[i]++;
            end
            for (int i = 0; i < NR; i++) begin
                has = drv_en && (src_pos[i] < src_len[i]);
                req_valid_i[i] = has && !(gaps && grant_o[i] && $urandom_range(0, 3) == 0);
                req_data_i[i]  = has ? src_mem[i][src_pos[i]][7:0] : 8'($urandom);
                req_last_i[i]  = has ? src_mem[i][src_pos[i]][8] : 1'($urandom);
            end
            case (ready_mode)
                0:       tx_ready_i = 1'b1;
                1:       tx_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: tx_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: per-cycle routing rules plus beat-by-beat scoreboard comparison.
    initial begin
        bit   prev_busy;
        bit   prev_flag;
        bit   prev_rel;
        exp_t e;
        prev_busy = 1'b0;
        prev_flag = 1'b0;
        prev_rel  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (arst_i) begin
                prev_busy = 1'b0;
                prev_flag = 1'b0;
                prev_rel  = 1'b0;
            end else begin
                if (prev_rel) check("release_next_cycle", busy_o, 0);
                else if (!prev_busy) check("arb_latency", busy_o, prev_flag);
                if (!busy_o) begin
                    check("idle_outputs", {grant_o, req_ready_o, tx_valid_o}, 0);
                end else begin
                    check("grant_onehot", grant_o, 1 << grant_id_o);
                    check("ready_route", req_ready_o, tx_ready_i ? grant_o : 4'b0);
                    check("valid_route", tx_valid_o, req_valid_i[grant_id_o]);
                end
                prev_rel = 1'b0;
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none t=%0t", tx_data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", tx_data_o, e.data);
                        check("beat_owner", grant_id_o, e.id);
                        prev_rel = e.rel;
                    end
                end
                prev_busy = busy_o;
                prev_flag = !busy_o && (|req_valid_i) && !flush_i;
            end
        end
    end

    task automatic drain(input string name);
        int n;
        int left;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_q.size());
            exp_q.delete();
        end
        left = 0;
        for (int i = 0; i < NR; i++) left += src_len[i] - src_pos[i];
        check({name, "_drained"}, left, 0);
        repeat (2) @(posedge clk_i);
        #2;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_grant"},    grant_o, 0);
        check({name, "_grant_id"}, grant_id_o, 0);
        check({name, "_busy"},     busy_o, 0);
        check({name, "_tx_valid"}, tx_valid_o, 0);
        check({name, "_tx_data"},  tx_data_o, 0);
        check({name, "_ready"},    req_ready_o, 0);
    endtask

    task automatic do_reset();
        drv_en = 1'b0;
        arst_i = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        arst_i    = 1'b0;
        model_ptr = 0;
    endtask

    initial begin
        int n;
        arst_i      = 1'b1;
        flush_i     = 1'b0;
        drv_en      = 1'b0;
        gaps        = 1'b0;
        ready_mode  = 0;
        cyc         = 0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_ready_i  = 1'b0;
        model_ptr   = 0;
        clear_src();
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk_i);
        #2;
        arst_i = 1'b0;

        // Single requester, 3-byte packet.
        clear_src();
        add_byte(0, 8'h41, 0);
        add_byte(0, 8'h42, 0);
        add_byte(0, 8'h43, 1);
        model_run(0);
        drv_en = 1'b1;
        drain("single");

        // Round robin with 1-byte packets.
        clear_src();
        add_byte(0, 8'h10, 1);
        add_byte(0, 8'h11, 1);
        add_byte(1, 8'h20, 1);
        add_byte(2, 8'h30, 1);
        add_byte(3, 8'h40, 1);
        model_run(0);
        drain("round_robin");

        // Burst cap: req2 streams 20 bytes, req3 waiting.
        clear_src();
        for (int b = 0; b < 20; b++) add_byte(2, 8'(8'h80 + b), b == 19);
        add_byte(3, 8'hc0, 0);
        add_byte(3, 8'hc1, 1);
        model_run(0);
        drain("burst_cap");

        // Backpressure on req1 with tx_ready 1,0,0,1 pattern.
        clear_src();
        ready_mode = 1;
        add_byte(1, 8'h5a, 0);
        add_byte(1, 8'h5b, 0);
        add_byte(1, 8'h5c, 1);
        model_run(0);
        drain("backpressure");
        ready_mode = 0;

        // Reset while a packet is in flight; requesters re-send afterwards.
        clear_src();
        for (int b = 0; b < 5; b++) add_byte(1, 8'(8'ha0 + b), b == 4);
        for (int b = 0; b < 4; b++) add_byte(3, 8'(8'hd0 + b), b == 3);
        model_run(0);
        n = 0;
        do begin
            @(posedge clk_i);
            #2;
            n++;
        end while (src_pos[1] + src_pos[3] < 2 && n < 200);
        check("mid_reset_progress", (src_pos[1] + src_pos[3] >= 2), 1);
        arst_i = 1'b1;
        drv_en = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        arst_i = 1'b0;
        for (int i = 0; i < NR; i++) src_pos[i] = 0;
        model_ptr = 0;
        exp_q.delete();
        model_run(0);
        drv_en = 1'b1;
        drain("after_reset");

        // Flush mid-packet of req0 while req1 waits.
        do_reset();
        clear_src();
        for (int b = 0; b < 6; b++) add_byte(0, 8'(8'h60 + b), b == 5);
        add_byte(1, 8'h70, 0);
        add_byte(1, 8'h71, 1);
        model_run(3);
        drv_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i);
            #2;
            n++;
        end while (src_pos[0] < 2 && n < 200);
        flush_i = 1'b1;
        @(posedge clk_i);
        #2;
        flush_i = 1'b0;
        drain("flush_xfer");

        // Flush held while idle blocks any new grant.
        flush_i = 1'b1;
        add_byte(2, 8'h99, 1);
        model_run(0);
        repeat (4) @(posedge clk_i);
        #2;
        check("flush_idle_hold", busy_o, 0);
        flush_i = 1'b0;
        drain("flush_idle");

        // Randomized packets, random backpressure and owner valid gaps.
        gaps       = 1'b1;
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            int npk;
            int len;
            clear_src();
            for (int i = 0; i < NR; i++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
                end
            end
            model_run(0);
            drain("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
